// File: rtl/wb_master_pkg.sv
// Shared types and CTI encodings for the Wishbone burst master.
package wb_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BEAT  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Single-beat bursts are classic cycles; otherwise the final beat carries end-of-burst.
  function automatic logic [2:0] beat_cti(input logic [2:0] beat, input logic [2:0] len);
    if (len == 3'd0) begin
      return CTI_CLASSIC;
    end else if (beat == len) begin
      return CTI_EOB;
    end else begin
      return CTI_INCR;
    end
  endfunction

endpackage

// File: rtl/wb_beat_timer.sv
// Per-beat ack watchdog: counts cycles a strobed beat waits for its ack.
module wb_beat_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Wait-cycle counter; saturates at the limit so expire stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: accepts one command, issues up to 8 incrementing
// beats, streams write data in and read data out, aborts on ack timeout.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 256
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic            cmd_we,
  input  logic [2:0]      cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int SW = DW / 8;
  localparam logic [AW-1:0] STEP = AW'(SW);

  state_t          state, state_nx;
  logic [2:0]      len_q, len_nx;
  logic [2:0]      beat_cnt, beat_nx;
  logic            cyc_nx, stb_nx, we_nx;
  logic [AW-1:0]   addr_nx;
  logic [DW-1:0]   dat_nx, rd_data_nx;
  logic [SW-1:0]   sel_nx;
  logic [2:0]      cti_nx;
  logic            rd_valid_nx, done_nx, err_nx;
  logic            beat_ack, last_beat, expire;

  // Acks only count while a beat is strobed; stray acks elsewhere are ignored.
  assign beat_ack  = (state == BEAT) && wb_ack_i;
  assign last_beat = (beat_cnt == len_q);
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == FETCH) || (beat_ack && !last_beat && wb_we_o);

  wb_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (sys_clk),
    .rst_n  (RESETN),
    .clear  ((state != BEAT) || wb_ack_i),
    .enable (state == BEAT),
    .expire (expire)
  );

  // Next-state and next registered-output values.
  always_comb begin
    state_nx    = state;
    len_nx      = len_q;
    beat_nx     = beat_cnt;
    cyc_nx      = wb_cyc_o;
    stb_nx      = wb_stb_o;
    we_nx       = wb_we_o;
    addr_nx     = wb_addr_o;
    dat_nx      = wb_dat_o;
    sel_nx      = wb_sel_o;
    cti_nx      = wb_cti_o;
    rd_data_nx  = rd_data;
    rd_valid_nx = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          len_nx  = cmd_len;
          beat_nx = 3'd0;
          addr_nx = cmd_addr;
          sel_nx  = cmd_sel;
          we_nx   = cmd_we;
          cti_nx  = beat_cti(3'd0, cmd_len);
          cyc_nx  = 1'b1;
          if (cmd_we) begin
            state_nx = FETCH;
            stb_nx   = 1'b0;
          end else begin
            state_nx = BEAT;
            stb_nx   = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          dat_nx   = wr_data;
          stb_nx   = 1'b1;
          state_nx = BEAT;
        end else begin
          state_nx = FETCH;
        end
      end
      BEAT: begin
        // An ack arriving on the expiry cycle still completes the beat.
        if (wb_ack_i) begin
          if (!wb_we_o) begin
            rd_data_nx  = wb_dat_i;
            rd_valid_nx = 1'b1;
          end else begin
            rd_valid_nx = 1'b0;
          end
          if (last_beat) begin
            state_nx = DONE;
            cyc_nx   = 1'b0;
            stb_nx   = 1'b0;
            done_nx  = 1'b1;
          end else begin
            addr_nx = wb_addr_o + STEP;
            beat_nx = beat_cnt + 3'd1;
            cti_nx  = beat_cti(beat_cnt + 3'd1, len_q);
            if (!wb_we_o) begin
              state_nx = BEAT;
            end else if (wr_valid) begin
              dat_nx   = wr_data;
              state_nx = BEAT;
            end else begin
              stb_nx   = 1'b0;
              state_nx = FETCH;
            end
          end
        end else if (expire) begin
          state_nx = ABORT;
          cyc_nx   = 1'b0;
          stb_nx   = 1'b0;
          err_nx   = 1'b1;
        end else begin
          state_nx = BEAT;
        end
      end
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        cyc_nx   = 1'b0;
        stb_nx   = 1'b0;
      end
    endcase
  end

  // State, burst bookkeeping and all registered outputs.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      len_q     <= 3'd0;
      beat_cnt  <= 3'd0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_cti_o  <= 3'b000;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      len_q     <= len_nx;
      beat_cnt  <= beat_nx;
      wb_cyc_o  <= cyc_nx;
      wb_stb_o  <= stb_nx;
      wb_we_o   <= we_nx;
      wb_addr_o <= addr_nx;
      wb_dat_o  <= dat_nx;
      wb_sel_o  <= sel_nx;
      wb_cti_o  <= cti_nx;
      rd_data   <= rd_data_nx;
      rd_valid  <= rd_valid_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule
